// File: rtl/aes_v3_pkg.sv
// Shared types, constants and GF(2^8) helpers for the AES column sequencer.
// The decrypt path is enabled by defining AES_V3_COL_SEQ_DEC_EN.
package aes_v3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Low byte of the AES field polynomial x^8+x^4+x^3+x+1 (0x11b).
  localparam logic [7:0] XTIME_POLY    = 8'h1b;
  localparam logic [7:0] SBOX_AFFINE_C = 8'h63;
  localparam logic [7:0] INV_AFFINE_C  = 8'h05;

  localparam logic [7:0] MIX_ENC_2  = 8'h02;
  localparam logic [7:0] MIX_ENC_3  = 8'h03;
  localparam logic [7:0] MIX_DEC_9  = 8'h09;
  localparam logic [7:0] MIX_DEC_11 = 8'h0b;
  localparam logic [7:0] MIX_DEC_13 = 8'h0d;
  localparam logic [7:0] MIX_DEC_14 = 8'h0e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? XTIME_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ SBOX_AFFINE_C;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ INV_AFFINE_C;
  endfunction

endpackage

// File: rtl/aes_v3_col_seq_if.sv
// Request/response bundle of the column sequencer: request fields from the
// master, result column and status from the slave.
interface aes_v3_col_seq_if;
  logic        valid;
  logic        dec;
  logic        mix;
  logic        flush;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] rd;
  logic        ready;
  logic        busy;

  modport master (
    output valid, dec, mix, flush, rs1, rs2,
    input  rd, ready, busy
  );

  modport slave (
    input  valid, dec, mix, flush, rs1, rs2,
    output rd, ready, busy
  );
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box computed from field inversion and the affine map;
// inv=1 selects the inverse S-box through the same inverter.
module aes_sbox
  import aes_v3_pkg::*;
(
  input  logic       inv,
  input  logic [7:0] in,
  output logic [7:0] out
);

  logic [7:0] w_pre;
  logic [7:0] w_recip;

  always_comb begin
    w_pre   = inv ? inv_affine(in) : in;
    w_recip = gf_inv(w_pre);
    out     = inv ? w_recip : sbox_affine(w_recip);
  end

endmodule

// File: rtl/aes_v3_col_seq.sv
// Byte-serial AES column step: (Inv)SubBytes, optional (Inv)MixColumns, XOR
// with rs2, one byte per cycle. Define AES_V3_COL_SEQ_DEC_EN for decryption.
module aes_v3_col_seq_core
  import aes_v3_pkg::*;
(
  input logic             g_clk,
  input logic             g_resetn,
  aes_v3_col_seq_if.slave bus
);

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_cnt;
  logic [31:0] r_rs1;
  logic [31:0] r_acc;
  logic [31:0] r_rd;
  logic        r_mix;
  logic        w_capture;
  logic        w_step;
  logic        w_sbox_inv;
  logic [7:0]  w_sbox_in;
  logic [7:0]  w_sbox_out;
  logic [31:0] w_term;
  logic [31:0] w_term_rot;
  logic [31:0] w_acc_next;

  assign w_capture = (r_state == ST_IDLE) && bus.valid && !bus.flush;
  assign w_step    = (r_state == ST_RUN) && !bus.flush;

`ifdef AES_V3_COL_SEQ_DEC_EN
  logic r_dec;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_dec <= 1'b0;
    end else if (w_capture) begin
      r_dec <= bus.dec;
    end
  end

  assign w_sbox_inv = r_dec;
`else
  logic w_dec_unused;
  assign w_dec_unused = bus.dec;
  assign w_sbox_inv   = 1'b0;
`endif

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flush overrides every transition, including a capture in IDLE.
  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.valid) w_state_next = ST_RUN;
        ST_RUN:  if (r_cnt == 2'd3) w_state_next = ST_DONE;
        ST_DONE: w_state_next = ST_IDLE;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.ready = (r_state == ST_DONE);
    bus.busy  = (r_state != ST_IDLE);
  end

  assign w_sbox_in = r_rs1[{r_cnt, 3'b000} +: 8];

  aes_sbox u_sbox (
    .inv (w_sbox_inv),
    .in  (w_sbox_in),
    .out (w_sbox_out)
  );

  always_comb begin
    w_term = {24'h000000, w_sbox_out};
    if (r_mix) begin
`ifdef AES_V3_COL_SEQ_DEC_EN
      if (r_dec)
        w_term = {gf_mul(w_sbox_out, MIX_DEC_11), gf_mul(w_sbox_out, MIX_DEC_13),
                  gf_mul(w_sbox_out, MIX_DEC_9),  gf_mul(w_sbox_out, MIX_DEC_14)};
      else
`endif
        w_term = {gf_mul(w_sbox_out, MIX_ENC_3), w_sbox_out,
                  w_sbox_out, gf_mul(w_sbox_out, MIX_ENC_2)};
    end
  end

  // Rotating byte k's term left by 8k lands its coefficients on the right rows.
  always_comb begin
    case (r_cnt)
      2'd0:    w_term_rot = w_term;
      2'd1:    w_term_rot = {w_term[23:0], w_term[31:24]};
      2'd2:    w_term_rot = {w_term[15:0], w_term[31:16]};
      default: w_term_rot = {w_term[7:0],  w_term[31:8]};
    endcase
  end

  assign w_acc_next = r_acc ^ w_term_rot;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_cnt <= 2'd0;
      r_rs1 <= 32'h0;
      r_acc <= 32'h0;
      r_rd  <= 32'h0;
      r_mix <= 1'b0;
    end else if (w_capture) begin
      r_cnt <= 2'd0;
      r_rs1 <= bus.rs1;
      r_acc <= bus.rs2;
      r_mix <= bus.mix;
    end else if (w_step) begin
      r_cnt <= r_cnt + 2'd1;
      r_acc <= w_acc_next;
      if (r_cnt == 2'd3) r_rd <= w_acc_next;
    end
  end

  assign bus.rd = r_rd;

endmodule

module aes_v3_col_seq (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        dec,
  input  logic        mix,
  input  logic        flush,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] rd,
  output logic        ready,
  output logic        busy
);

  aes_v3_col_seq_if u_bus ();

  assign u_bus.valid = valid;
  assign u_bus.dec   = dec;
  assign u_bus.mix   = mix;
  assign u_bus.flush = flush;
  assign u_bus.rs1   = rs1;
  assign u_bus.rs2   = rs2;
  assign rd          = u_bus.rd;
  assign ready       = u_bus.ready;
  assign busy        = u_bus.busy;

  aes_v3_col_seq_core u_core (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (u_bus)
  );

endmodule

// File: doc/aes_v3_col_seq.md
AES_V3_COL_SEQ -- requirements
Module: aes_v3_col_seq

Interface
REQ-001 SHALL have port g_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port g_resetn, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port valid, input, 1 bit: request present; sampled only in IDLE.
REQ-004 SHALL have port dec, input, 1 bit: 0 = encrypt (forward S-box, MixColumns); 1 = decrypt (inverse S-box, InvMixColumns).
REQ-005 SHALL have port mix, input, 1 bit: 1 = apply (Inv)MixColumns after (Inv)SubBytes; 0 = (Inv)SubBytes only.
REQ-006 SHALL have port flush, input, 1 bit: abort any in-flight operation.
REQ-007 SHALL have port rs1, input, 32 bits: state column; byte k = rs1[8k+7:8k].
REQ-008 SHALL have port rs2, input, 32 bits: value XORed into the result, e.g. a round-key column.
REQ-009 SHALL have port rd, output, 32 bits: result column.
REQ-010 SHALL have port ready, output, 1 bit: one-cycle pulse; rd is valid in that cycle.
REQ-011 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 IDLE with valid=1 and flush=0 SHALL capture rs1, rs2, dec and mix, clear the byte counter to 0, and move to RUN; inputs are don't-care after capture.
REQ-014 RUN SHALL process byte k = counter each cycle:
  - s = sbox(rs1_q byte k), using the inverse S-box when dec_q=1.
  - mix_q=1: column term {b3,b2,b1,b0} = {3s,s,s,2s} when encrypting; {11s,13s,9s,14s} when decrypting.
  - mix_q=0: column term = {24'b0,s}.
  - The term SHALL be rotated left by 8k bits and XORed into the accumulator.
REQ-015 The GF(2^8) multiply SHALL reduce modulo 0x11b.
REQ-016 The accumulator SHALL be initialised to rs2 at capture.
REQ-017 The byte counter SHALL be 2 bits; RUN moves to DONE when counter=3, with no wrap-around into a fifth byte.
REQ-018 DONE SHALL assert ready for exactly one cycle, drive rd = accumulator, then return to IDLE.
REQ-019 Latency SHALL be fixed at 5 cycles: capture edge, four RUN edges, ready high in the DONE cycle.
REQ-020 rd SHALL hold its last value until the next DONE.
REQ-021 A valid seen in DONE SHALL be ignored; back-to-back throughput is one op per 6 cycles.
REQ-022 flush=1 in any state SHALL force IDLE on the next edge, with no ready pulse and rd unchanged.
REQ-023 When flush and valid are both high in IDLE, flush SHALL win and no capture occurs.
REQ-024 Exactly one S-box instance SHALL be used.

Reset
REQ-025 g_resetn=0 SHALL asynchronously set state=IDLE, counter=0, accumulator=0, rd=0, ready=0 and busy=0.
REQ-026 Reset mid-RUN SHALL discard the operation; no ready is produced after release.

Configuration
REQ-027 Macro AES_V3_COL_SEQ_DEC_EN defined: decrypt path present and dec honoured.
REQ-028 Macro AES_V3_COL_SEQ_DEC_EN undefined: dec SHALL be treated as 0, the inverse S-box and the 9/11/13/14 multipliers are removed, and a request with dec=1 returns the encrypt result.

Structure
REQ-029 A shared package (aes_v3_pkg) SHALL hold the FSM state typedef, the xtime reduction constant 8'h1b, and the mix-coefficient constants.
REQ-030 The S-box SHALL be the existing sub-module aes_sbox (ports inv, in, out).

Verification
REQ-031 Scenario: rs1=0x6850829f, rs2=0, dec=0, mix=1 -> rd=0xbca14d8e, ready exactly 5 cycles after the capture edge.
REQ-032 Scenario: same rs1, mix=0, rs2=0xffffffff -> rd=0xbaacec24.
REQ-033 Scenario: rs1=0x6532e319, rs2=0, dec=1, mix=1 -> rd=0x455313db (only with AES_V3_COL_SEQ_DEC_EN).
REQ-034 Scenario: flush pulsed in the 2nd RUN cycle -> no ready, busy=0 next cycle, rd keeps its previous value; a new op then completes correctly.
REQ-035 Scenario: g_resetn deasserted during RUN -> all outputs 0 immediately, no ready after release.
REQ-036 Scenario: valid held high continuously -> ready pulses every 6 cycles with correct results each time.
